// File: rtl/sm4_req_arbiter_if.sv
// sm4_req_arbiter_if: requester, encryptor and status signals of sm4_req_arbiter.
// The master modport is the arbiter side; the slave modport is the requester/encryptor side.
interface sm4_req_arbiter_if #(
  parameter int num_req_p    = 4,
  parameter int group_size_p = 128
);
  localparam int id_width_lp = $clog2(num_req_p);
  logic [num_req_p-1:0]                   req_v_i;
  logic [num_req_p-1:0]                   req_ready_o;
  logic [num_req_p-1:0][group_size_p-1:0] req_content_i;
  logic [num_req_p-1:0][group_size_p-1:0] req_key_i;
  logic [num_req_p-1:0]                   req_decode_i;
  logic [num_req_p-1:0]                   resp_v_o;
  logic [group_size_p-1:0]                resp_crypt_o;
  logic [num_req_p-1:0]                   resp_yumi_i;
  logic [group_size_p-1:0]                enc_content_o;
  logic [group_size_p-1:0]                enc_key_o;
  logic                                   enc_decode_o;
  logic                                   enc_v_o;
  logic                                   enc_ready_i;
  logic [group_size_p-1:0]                enc_crypt_i;
  logic                                   enc_v_i;
  logic                                   enc_yumi_o;
  logic                                   enc_invalid_cache_o;
  logic [id_width_lp-1:0]                 grant_id_o;
  logic                                   busy_o;
  modport master (
    input  req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
           enc_ready_i, enc_crypt_i, enc_v_i,
    output req_ready_o, resp_v_o, resp_crypt_o, enc_content_o, enc_key_o,
           enc_decode_o, enc_v_o, enc_yumi_o, enc_invalid_cache_o, grant_id_o, busy_o
  );
  modport slave (
    output req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
           enc_ready_i, enc_crypt_i, enc_v_i,
    input  req_ready_o, resp_v_o, resp_crypt_o, enc_content_o, enc_key_o,
           enc_decode_o, enc_v_o, enc_yumi_o, enc_invalid_cache_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/sm4_req_arbiter.sv
// sm4_req_arbiter: round-robin sharing of one sm4_encryptor among num_req_p requesters.
// Define SM4_ARB_FLUSH_EN to flush the encryptor cache whenever the served requester changes.
module sm4_req_arbiter #(
  parameter int num_req_p    = 4,
  parameter int group_size_p = 128
) (
  input logic               clk_i,
  input logic               reset_ni,
  sm4_req_arbiter_if.master bus
);
  localparam int id_width_lp = $clog2(num_req_p);
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ISSUE, S_BUSY, S_RESP} state_e;
  state_e                  r_state, w_next;
  logic [id_width_lp-1:0]  r_rr, r_grant, w_winner, w_cand;
  logic [group_size_p-1:0] r_content, r_key, r_result;
  logic                    r_decode, w_found, w_flush, w_enc_v, w_yumi;
  logic [num_req_p-1:0]    w_ready, w_resp_v;
  // Walk downward so the last hit is the one nearest the round-robin pointer.
  always_comb begin
    w_winner = r_rr;
    w_found  = 1'b0;
    w_cand   = r_rr;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      w_cand = id_width_lp'((int'(r_rr) + i) % num_req_p);
      if (bus.req_v_i[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end
`ifdef SM4_ARB_FLUSH_EN
  logic [id_width_lp-1:0] r_last_id;
  logic                   r_last_valid;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_last_id    <= '0;
      r_last_valid <= 1'b0;
    end else if (r_state == S_RESP && bus.resp_yumi_i[r_grant]) begin
      r_last_id    <= r_grant;
      r_last_valid <= 1'b1;
    end
  assign w_flush                 = r_last_valid && (w_winner != r_last_id);
  assign bus.enc_invalid_cache_o = (r_state == S_FLUSH);
`else
  assign w_flush                 = 1'b0;
  assign bus.enc_invalid_cache_o = 1'b0;
`endif
  always_comb begin
    w_next   = r_state;
    w_ready  = '0;
    w_resp_v = '0;
    w_enc_v  = 1'b0;
    w_yumi   = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_found) begin
        w_ready[w_winner] = 1'b1;
        w_next            = w_flush ? S_FLUSH : S_ISSUE;
      end
      S_FLUSH: w_next = S_ISSUE;
      S_ISSUE: begin
        w_enc_v = 1'b1;
        w_next  = bus.enc_ready_i ? S_BUSY : S_ISSUE;
      end
      S_BUSY: begin
        w_yumi = bus.enc_v_i;
        w_next = bus.enc_v_i ? S_RESP : S_BUSY;
      end
      S_RESP: begin
        w_resp_v[r_grant] = 1'b1;
        w_next            = bus.resp_yumi_i[r_grant] ? S_IDLE : S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // Operands are held from grant to completion since the encryptor samples them late.
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_content <= '0;
      r_key     <= '0;
      r_decode  <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_content <= bus.req_content_i[w_winner];
        r_key     <= bus.req_key_i[w_winner];
        r_decode  <= bus.req_decode_i[w_winner];
        r_grant   <= w_winner;
      end
      if (r_state == S_BUSY && bus.enc_v_i)
        r_result <= bus.enc_crypt_i;
      if (r_state == S_RESP && bus.resp_yumi_i[r_grant])
        r_rr <= (int'(r_grant) == num_req_p - 1) ? '0 : r_grant + 1'b1;
    end
  assign bus.req_ready_o   = w_ready;
  assign bus.resp_v_o      = w_resp_v;
  assign bus.resp_crypt_o  = (r_state == S_RESP) ? r_result : '0;
  assign bus.enc_content_o = r_content;
  assign bus.enc_key_o     = r_key;
  assign bus.enc_decode_o  = r_decode;
  assign bus.enc_v_o       = w_enc_v;
  assign bus.enc_yumi_o    = w_yumi;
  assign bus.grant_id_o    = r_grant;
  assign bus.busy_o        = (r_state != S_IDLE);
endmodule

// File: tb/tb_sm4_req_arbiter.sv
// tb_sm4_req_arbiter: directed and random requests against a round-robin reference model,
// with a behavioural stand-in for sm4_encryptor that knows the standard SM4 vector.
module tb_sm4_req_arbiter;
  localparam int N = 4;
  localparam logic [127:0] KV = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CV = 128'h681edf34d206965e86b3e94f536e4246;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  int total = 0;
  int bad = 0;

  int           rr_m = 0;
  int           last_id_m = 0;
  bit           last_valid_m = 1'b0;
  logic [127:0] cont_m [N];
  logic [127:0] key_m  [N];
  logic         dec_m  [N];

  sm4_req_arbiter_if #(.num_req_p(N)) bus ();
  sm4_req_arbiter #(.num_req_p(N)) dut (.clk_i(clk_i), .reset_ni(reset_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Encryptor stand-in: exact for the standard vector, an invertible scramble otherwise.
  function automatic logic [127:0] enc_f(input logic [127:0] c, input logic [127:0] k, input logic d);
    if (k == KV && !d && c == KV) return CV;
    if (k == KV && d && c == CV) return KV;
    return c ^ {k[63:0], k[127:64]} ^ {128{d}};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = 0; i < N; i++)
      if (v[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encryptor stand-in process: accepts on v&ready, answers after a random delay.
  logic [127:0] em_c;
  bit           em_busy = 1'b0;
  int           em_cnt = 0;
  initial begin
    bit fin, fout;
    bus.enc_ready_i = 1'b0;
    bus.enc_v_i     = 1'b0;
    bus.enc_crypt_i = '0;
    em_c            = '0;
    forever begin
      @(negedge clk_i);
      #1;
      fin  = bus.enc_v_o && bus.enc_ready_i;
      fout = bus.enc_v_i && bus.enc_yumi_o;
      if (em_busy && reset_ni) chk("enc_content_stable", bus.enc_content_o, em_c);
      @(posedge clk_i);
      #2;
      if (!reset_ni) begin
        em_busy         = 1'b0;
        bus.enc_v_i     = 1'b0;
        bus.enc_ready_i = 1'b0;
      end else begin
        if (fout) begin
          bus.enc_v_i = 1'b0;
          em_busy     = 1'b0;
        end
        if (fin) begin
          em_busy = 1'b1;
          em_c    = bus.enc_content_o;
          em_cnt  = $urandom_range(0, 3);
        end else if (em_busy && !bus.enc_v_i) begin
          if (em_cnt == 0) begin
            bus.enc_v_i     = 1'b1;
            bus.enc_crypt_i = enc_f(bus.enc_content_o, bus.enc_key_o, bus.enc_decode_o);
          end else em_cnt--;
        end
        bus.enc_ready_i = !em_busy && ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_content_i[i] = cont_m[i];
      bus.req_key_i[i]     = key_m[i];
      bus.req_decode_i[i]  = dec_m[i];
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      cont_m[i] = {$urandom, $urandom, $urandom, $urandom};
      key_m[i]  = {$urandom, $urandom, $urandom, $urandom};
      dec_m[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    reset_ni        = 1'b0;
    bus.req_v_i     = '0;
    bus.resp_yumi_i = '0;
    repeat (2) @(negedge clk_i);
    reset_ni     = 1'b1;
    rr_m         = 0;
    last_valid_m = 1'b0;
  endtask

  // Called at a negedge; issues one request vector and drives the winner to completion.
  task automatic run_op(input logic [N-1:0] v, input int bp, input bit scramble);
    int w, cyc;
    bit flush, prev_yumi;
    logic [127:0] exp;
    w     = pick(v, rr_m);
    flush = 1'b0;
`ifdef SM4_ARB_FLUSH_EN
    flush = last_valid_m && (w != last_id_m);
`endif
    exp = enc_f(cont_m[w], key_m[w], dec_m[w]);
    apply_ops();
    bus.req_v_i = v;
    #1;
    chk("accept_ready", bus.req_ready_o, 128'(1 << w));
    @(negedge clk_i);
    if (scramble) begin
      randomize_ops();
      apply_ops();
    end
    chk("grant_id", bus.grant_id_o, 128'(w));
    chk("busy_after_accept", bus.busy_o, 1);
    if (flush) begin
      chk("flush_pulse", bus.enc_invalid_cache_o, 1);
      chk("flush_no_enc_v", bus.enc_v_o, 0);
      @(negedge clk_i);
    end
    chk("no_flush", bus.enc_invalid_cache_o, 0);
    chk("enc_v_latency", bus.enc_v_o, 1);
    cyc       = 0;
    prev_yumi = 1'b0;
    while (bus.resp_v_o === '0 && cyc < 60) begin
      chk("ready_low_busy", bus.req_ready_o, 0);
      chk("yumi_tracks_v", bus.enc_yumi_o, bus.enc_v_i && !bus.enc_v_o);
      prev_yumi = bus.enc_yumi_o;
      @(negedge clk_i);
      cyc++;
    end
    chk("resp_latency", prev_yumi, 1);
    chk("resp_v", bus.resp_v_o, 128'(1 << w));
    chk("resp_crypt", bus.resp_crypt_o, exp);
    chk("grant_held", bus.grant_id_o, 128'(w));
    for (int b = 0; b < bp; b++) begin
      bus.resp_yumi_i = N'(1 << ((w + 1) % N));
      @(negedge clk_i);
      chk("bp_resp_v", bus.resp_v_o, 128'(1 << w));
      chk("bp_resp_crypt", bus.resp_crypt_o, exp);
      chk("bp_ready", bus.req_ready_o, 0);
      chk("bp_busy", bus.busy_o, 1);
    end
    bus.resp_yumi_i = N'(1 << w);
    #1;
    chk("no_accept_in_resp", bus.req_ready_o, 0);
    @(negedge clk_i);
    bus.resp_yumi_i = '0;
    bus.req_v_i     = '0;
    #1;
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_resp_v", bus.resp_v_o, 0);
    chk("idle_resp_crypt", bus.resp_crypt_o, 0);
    rr_m         = (w + 1) % N;
    last_id_m    = w;
    last_valid_m = 1'b1;
  endtask

  initial begin
    int cyc;
    bus.req_v_i     = '0;
    bus.resp_yumi_i = '0;
    for (int i = 0; i < N; i++) begin
      cont_m[i] = '0;
      key_m[i]  = '0;
      dec_m[i]  = 1'b0;
    end
    apply_ops();
    repeat (2) @(negedge clk_i);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_grant", bus.grant_id_o, 0);
    chk("rst_resp_v", bus.resp_v_o, 0);
    chk("rst_resp_crypt", bus.resp_crypt_o, 0);
    chk("rst_enc_v", bus.enc_v_o, 0);
    chk("rst_enc_yumi", bus.enc_yumi_o, 0);
    chk("rst_enc_content", bus.enc_content_o, 0);
    chk("rst_enc_inv", bus.enc_invalid_cache_o, 0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    cont_m[2] = KV; key_m[2] = KV; dec_m[2] = 1'b0;
    run_op(4'b0100, 0, 1'b0);

    do_reset();
    randomize_ops();
    repeat (5) run_op(4'b1111, 0, 1'b0);

    cont_m[1] = KV; key_m[1] = KV; dec_m[1] = 1'b0;
    run_op(4'b0010, 10, 1'b0);
    cont_m[1] = CV; dec_m[1] = 1'b1;
    run_op(4'b0010, 0, 1'b1);

    do_reset();
    run_op(4'b0001, 0, 1'b0);
    run_op(4'b0001, 0, 1'b0);
    run_op(4'b0100, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      randomize_ops();
      run_op(N'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b1);
    end

    randomize_ops();
    apply_ops();
    bus.req_v_i = 4'b1000;
    cyc = 0;
    while (!(bus.busy_o === 1'b1 && bus.enc_v_o === 1'b0 && bus.resp_v_o === '0 &&
             bus.enc_invalid_cache_o === 1'b0) && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("reach_busy", cyc < 60, 1);
    reset_ni    = 1'b0;
    bus.req_v_i = '0;
    #1;
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_resp_v", bus.resp_v_o, 0);
    chk("midrst_enc_v", bus.enc_v_o, 0);
    chk("midrst_enc_yumi", bus.enc_yumi_o, 0);
    repeat (2) @(negedge clk_i);
    reset_ni     = 1'b1;
    rr_m         = 0;
    last_valid_m = 1'b0;
    run_op(4'b1000, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
